// File: rtl/data_mem_responder_pkg.sv
// Shared types and width helpers for the data-port memory responder.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int WAIT_STATES_MAX = 15;
  localparam int CNT_W           = 4;

  // Byte-offset bits inside one data word.
  function automatic int off_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int idx_bits(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/data_mem_responder_ram.sv
// Single-port word RAM with per-byte write enables and a registered, held read port.
module data_mem_responder_ram
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATA_WIDTH/8-1:0]        we,
  input  logic                           re,
  input  logic [idx_bits(DEPTH_WORDS)-1:0] idx,
  input  logic [DATA_WIDTH-1:0]          wdata,
  output logic [DATA_WIDTH-1:0]          rdata
);

  localparam int BE_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Byte-lane writes; storage is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (we[b]) begin
        mem_r[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Read register only moves on a read, so it holds across writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DATA_WIDTH{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[idx];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder: request latch, wait-state FSM and byte-enabled RAM for the core's M stage.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    MemEn,
  input  logic                    MemWrite,
  input  logic [DATA_WIDTH/8-1:0] ByteEn,
  input  logic [DATA_WIDTH-1:0]   MemAdr,
  input  logic [DATA_WIDTH-1:0]   MemWriteData,
  output logic [DATA_WIDTH-1:0]   MemReadData,
  output logic                    MemReady,
  output logic                    MemStall,
  output logic                    MisalignErr
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF   = off_bits(DATA_WIDTH);
  localparam int IDX_W = idx_bits(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

  state_e            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic              accept_s, done_nxt_s;
  logic              ready_r, mis_err_r;

  logic              lat_write_r, lat_mis_r;
  logic [BE_W-1:0]   lat_be_r;
  logic [IDX_W-1:0]  lat_idx_r;
  logic [DATA_WIDTH-1:0] lat_data_r;

  logic              in_mis_s, op_write_s, op_mis_s;
  logic [IDX_W-1:0]  in_idx_s, op_idx_s;
  logic [BE_W-1:0]   op_be_s, ram_we_s;
  logic [DATA_WIDTH-1:0] op_data_s;
  logic              ram_re_s;
  logic              unused_adr_s;

  assign in_idx_s     = MemAdr[IDX_W+OFF-1:OFF];
  assign in_mis_s     = (MemAdr[OFF-1:0] != {OFF{1'b0}});
  assign unused_adr_s = ^MemAdr[DATA_WIDTH-1:IDX_W+OFF];

  // Next-state and wait counter; IDLE and DONE accept requests identically.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (MemEn) begin
          accept_s = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = WAIT_LOAD;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_nxt_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // With zero wait states the RAM is driven straight from the accepted request.
  always_comb begin
    op_write_s = lat_write_r;
    op_mis_s   = lat_mis_r;
    op_be_s    = lat_be_r;
    op_idx_s   = lat_idx_r;
    op_data_s  = lat_data_r;
    if (accept_s) begin
      op_write_s = MemWrite;
      op_mis_s   = in_mis_s;
      op_be_s    = ByteEn;
      op_idx_s   = in_idx_s;
      op_data_s  = MemWriteData;
    end else begin
      op_write_s = lat_write_r;
    end
  end

  assign done_nxt_s = (state_nxt_s == ST_DONE);
  assign ram_we_s   = (reset && done_nxt_s && op_write_s && !op_mis_s) ? op_be_s : {BE_W{1'b0}};
  assign ram_re_s   = reset && done_nxt_s && !op_write_s;

  // State, counter and completion flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      ready_r   <= 1'b0;
      mis_err_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      ready_r   <= done_nxt_s;
      mis_err_r <= done_nxt_s & op_mis_s;
    end
  end

  // Request latch; WAIT ignores the bus entirely.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_write_r <= 1'b0;
      lat_mis_r   <= 1'b0;
      lat_be_r    <= {BE_W{1'b0}};
      lat_idx_r   <= {IDX_W{1'b0}};
      lat_data_r  <= {DATA_WIDTH{1'b0}};
    end else if (accept_s) begin
      lat_write_r <= MemWrite;
      lat_mis_r   <= in_mis_s;
      lat_be_r    <= ByteEn;
      lat_idx_r   <= in_idx_s;
      lat_data_r  <= MemWriteData;
    end else begin
      lat_write_r <= lat_write_r;
    end
  end

  data_mem_responder_ram #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .rst_n (reset),
    .we    (ram_we_s),
    .re    (ram_re_s),
    .idx   (op_idx_s),
    .wdata (op_data_s),
    .rdata (MemReadData)
  );

  assign MemReady    = ready_r;
  assign MisalignErr = mis_err_r;
  assign MemStall    = (state_r == ST_WAIT) || ((state_r != ST_WAIT) && MemEn);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (0 and 3 wait states) against an array memory model.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        men   [2];
  logic        mwr   [2];
  logic [3:0]  mbe   [2];
  logic [31:0] madr  [2];
  logic [31:0] mwd   [2];
  logic [31:0] mrd   [2];
  logic        mrdy  [2];
  logic        mstall[2];
  logic        mmis  [2];

  logic [31:0] model_mem [2][DEPTH];
  logic [31:0] last_rd   [2];
  int          ws        [2];
  int          tests  = 0;
  int          failed = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(rst_n[0]), .MemEn(men[0]), .MemWrite(mwr[0]), .ByteEn(mbe[0]),
    .MemAdr(madr[0]), .MemWriteData(mwd[0]), .MemReadData(mrd[0]), .MemReady(mrdy[0]),
    .MemStall(mstall[0]), .MisalignErr(mmis[0]));

  data_mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) dut1 (
    .clk(clk), .reset(rst_n[1]), .MemEn(men[1]), .MemWrite(mwr[1]), .ByteEn(mbe[1]),
    .MemAdr(madr[1]), .MemWriteData(mwd[1]), .MemReadData(mrd[1]), .MemReady(mrdy[1]),
    .MemStall(mstall[1]), .MisalignErr(mmis[1]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] adr);
    return int'(adr[11:2]);
  endfunction

  // Spec-level effect of a completed request on the model memory.
  task automatic model_apply(input int u, input bit we, input logic [3:0] be,
                             input logic [31:0] adr, input logic [31:0] wd);
    logic [31:0] w;
    if (we && adr[1:0] == 2'd0) begin
      w = model_mem[u][widx(adr)];
      for (int b = 0; b < 4; b++) begin
        if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
      end
      model_mem[u][widx(adr)] = w;
    end
  endtask

  // Waits for MemReady; stall must be high on every cycle before it. Optionally scribbles on the bus.
  task automatic wait_ready(input int u, input bit garbage, output int lat);
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (mrdy[u]) begin
        lat = k;
      end else begin
        check("stall_wait", 32'(mstall[u]), 32'd1);
        if (garbage) begin
          men[u] = 1'b1; mwr[u] = 1'bx; madr[u] = $urandom; mwd[u] = $urandom; mbe[u] = 4'($urandom);
        end
      end
    end
    if (lat == 0) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic single(input int u, input bit we, input logic [3:0] be,
                        input logic [31:0] adr, input logic [31:0] wd);
    int lat;
    logic [31:0] exp_rd;
    @(negedge clk);
    men[u] = 1'b1; mwr[u] = we; mbe[u] = be; madr[u] = adr; mwd[u] = wd;
    #1 check("stall_accept", 32'(mstall[u]), 32'd1);
    exp_rd = we ? last_rd[u] : model_mem[u][widx(adr)];
    model_apply(u, we, be, adr, wd);
    wait_ready(u, 1'b1, lat);
    men[u] = 1'b0;
    check("latency", 32'(lat), 32'(1 + ws[u]));
    check("misalign", 32'(mmis[u]), 32'(adr[1:0] != 2'd0));
    check(we ? "rdata_hold" : "rdata", mrd[u], exp_rd);
    #1 check("stall_done_idle", 32'(mstall[u]), 32'd0);
    last_rd[u] = exp_rd;
    @(negedge clk);
    check("ready_pulse", 32'(mrdy[u]), 32'd0);
  endtask

  // Write then read with MemEn held high throughout.
  task automatic b2b(input int u, input logic [31:0] wadr, input logic [31:0] wd,
                     input logic [31:0] radr);
    int lat;
    @(negedge clk);
    men[u] = 1'b1; mwr[u] = 1'b1; mbe[u] = 4'hF; madr[u] = wadr; mwd[u] = wd;
    model_apply(u, 1'b1, 4'hF, wadr, wd);
    wait_ready(u, 1'b0, lat);
    check("b2b_wr_latency", 32'(lat), 32'(1 + ws[u]));
    mwr[u] = 1'b0; madr[u] = radr;
    wait_ready(u, 1'b0, lat);
    check("b2b_rd_latency", 32'(lat), 32'(1 + ws[u]));
    check("b2b_rdata", mrd[u], model_mem[u][widx(radr)]);
    last_rd[u] = model_mem[u][widx(radr)];
    men[u] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    logic [31:0] a;
    ws[0] = 0; ws[1] = 3;
    for (int u = 0; u < 2; u++) begin
      rst_n[u] = 1'b0; men[u] = 1'b0; mwr[u] = 1'b0; mbe[u] = 4'h0;
      madr[u] = 32'h0; mwd[u] = 32'h0; last_rd[u] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_ready", 32'(mrdy[u]), 32'd0);
      check("rst_rdata", mrd[u], 32'h0);
      check("rst_mis", 32'(mmis[u]), 32'd0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);
    check("idle_no_stall", 32'(mstall[0]), 32'd0);

    // Preload the first 64 words of both instances.
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 64; i++) single(u, 1'b1, 4'hF, 32'(i * 4), $urandom);

    // Zero wait states: full write, read, partial write, misaligned write, address wrap.
    single(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    single(0, 1'b0, 4'h0, 32'h10, 32'h0);
    check("full_wr_rd", mrd[0], 32'hDEADBEEF);
    single(0, 1'b1, 4'b0010, 32'h10, 32'h0000AB00);
    single(0, 1'b0, 4'h0, 32'h10, 32'h0);
    check("partial_wr", mrd[0], 32'hDEADABEF);
    single(0, 1'b1, 4'hF, 32'h13, 32'hFFFFFFFF);
    single(0, 1'b1, 4'h0, 32'h14, 32'h11111111);
    single(0, 1'b0, 4'h0, 32'h10, 32'h0);
    check("misalign_no_write", mrd[0], 32'hDEADABEF);
    single(0, 1'b0, 4'h0, 32'hABCD1012, 32'h0);
    check("wrap_misalign_rd", mrd[0], 32'hDEADABEF);
    b2b(0, 32'h40, 32'h55AA55AA, 32'h40);

    // Three wait states: latency, stall window, back-to-back.
    single(1, 1'b1, 4'hF, 32'h20, 32'h12345678);
    single(1, 1'b0, 4'h0, 32'h20, 32'h0);
    check("ws3_read", mrd[1], 32'h12345678);
    b2b(1, 32'h40, 32'h55AA55AA, 32'h40);

    // Reset while a write to 0x50 is waiting.
    single(1, 1'b1, 4'hF, 32'h50, 32'h0);
    @(negedge clk);
    men[1] = 1'b1; mwr[1] = 1'b1; mbe[1] = 4'hF; madr[1] = 32'h50; mwd[1] = 32'hCAFEF00D;
    @(negedge clk);
    men[1] = 1'b0;
    check("pre_rst_stall", 32'(mstall[1]), 32'd1);
    rst_n[1] = 1'b0;
    #1;
    check("mid_rst_ready", 32'(mrdy[1]), 32'd0);
    check("mid_rst_rdata", mrd[1], 32'h0);
    check("mid_rst_stall", 32'(mstall[1]), 32'd0);
    last_rd[1] = 32'h0;
    repeat (5) begin
      @(negedge clk);
      check("rst_no_ready", 32'(mrdy[1]), 32'd0);
    end
    rst_n[1] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_no_ready", 32'(mrdy[1]), 32'd0);
    end
    single(1, 1'b0, 4'h0, 32'h50, 32'h0);

    // Random traffic over the preloaded words, with ignored upper bits and odd offsets.
    for (int u = 0; u < 2; u++) begin
      for (int n = 0; n < 60; n++) begin
        a = {$urandom_range(0, 15) == 0 ? 20'($urandom) : 20'h0,
             4'h0, 6'($urandom_range(0, 63)), 2'b00};
        if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
        single(u, 1'($urandom), 4'($urandom), a, $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=1 expected=0");
    $fatal(1, "timeout");
  end

endmodule
